// File: rtl/config_loader_pkg.sv
// Shared types and constants for the config_loader AXI-lite write master.
// Word order in layer_desc_t matches the order the words are written.
package config_loader_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int EPOCH_WIDTH = 8;
  localparam int CFG_WORDS   = 4;
  localparam int WORD_IDX_W  = $clog2(CFG_WORDS);

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [3:0] WSTRB_ALL     = 4'hF;

  typedef struct packed {
    logic [31:0] compute_cycles;
    logic [31:0] config_bits;
    logic [31:0] pointer_walks;
    logic [31:0] data_size;
  } layer_desc_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SEND,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_RUN
  } seq_state_e;

  function automatic logic [DATA_WIDTH-1:0] desc_word(input layer_desc_t d,
                                                      input logic [WORD_IDX_W-1:0] idx);
    logic [DATA_WIDTH-1:0] w;
    case (idx)
      2'd0:    w = d.compute_cycles;
      2'd1:    w = d.config_bits;
      2'd2:    w = d.pointer_walks;
      default: w = d.data_size;
    endcase
    return w;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [WORD_IDX_W-1:0] idx);
    return base + ADDR_WIDTH'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/config_loader_if.sv
// Descriptor stream plus AXI-lite write channels seen by config_loader.
// master = loader side, slave = descriptor source and AXI target side.
interface config_loader_if;
  import config_loader_pkg::*;

  logic                  desc_valid;
  logic                  desc_ready;
  layer_desc_t           desc;

  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  modport master (
    input  desc_valid,
    input  desc,
    output desc_ready,
    output m_axi_awaddr,
    output m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata,
    output m_axi_wstrb,
    output m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp,
    input  m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output desc_valid,
    output desc,
    input  desc_ready,
    input  m_axi_awaddr,
    input  m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata,
    input  m_axi_wstrb,
    input  m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp,
    output m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/config_loader_axil_single_write.sv
// One AXI-lite write (AW + W in any order, then B) per start pulse.
// A start accepted together with the B handshake chains straight into the next write.
module config_loader_axil_single_write
  import config_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic                  w_hs_o,
  output logic                  done_o,
  output logic                  err_o
);

  wr_state_e             state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic aw_hs;
  logic w_hs;
  logic load;

  assign aw_hs = awvalid_q && awready_i;
  assign w_hs  = wvalid_q && wready_i;
  assign load  = start_i && ((state_q == WR_IDLE) || ((state_q == WR_RESP) && bvalid_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Same-cycle handshakes count, so AW and W may both complete on one edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WR_IDLE: if (start_i) state_d = WR_SEND;
      WR_SEND: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      WR_RESP: if (bvalid_i) state_d = start_i ? WR_SEND : WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (load) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      addr_d    = addr_i;
      data_d    = data_i;
    end
    if (aw_hs) begin
      awvalid_d = 1'b0;
      aw_done_d = 1'b1;
    end
    if (w_hs) begin
      wvalid_d = 1'b0;
      w_done_d = 1'b1;
    end
    if ((state_q == WR_SEND) && (state_d == WR_RESP)) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    awaddr_o  = addr_q;
    awvalid_o = awvalid_q;
    wdata_o   = data_q;
    wstrb_o   = WSTRB_ALL;
    wvalid_o  = wvalid_q;
    bready_o  = (state_q == WR_RESP);
    w_hs_o    = w_hs;
    done_o    = (state_q == WR_RESP) && bvalid_i;
    err_o     = (state_q == WR_RESP) && bvalid_i && (bresp_i != AXI_RESP_OKAY);
  end

endmodule

// File: rtl/config_loader.sv
// Sequences the four config words of a layer descriptor onto AXI-lite, then
// waits for config_manager's epoch to move before accepting the next layer.
module config_loader
  import config_loader_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    MAX_LAYERS_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  config_loader_if.master          bus,
  input  logic [EPOCH_WIDTH-1:0]   current_epoch,
  output logic                     busy,
  output logic                     flip_pending,
  output logic                     resp_err,
  output logic [MAX_LAYERS_W-1:0]  layers_done
);

  seq_state_e              state_q, state_d;
  layer_desc_t             desc_q, desc_d;
  logic [WORD_IDX_W-1:0]   word_idx_q, word_idx_d;
  logic                    flip_pending_q, flip_pending_d;
  logic [EPOCH_WIDTH-1:0]  epoch_snap_q, epoch_snap_d;
  logic                    resp_err_q, resp_err_d;
  logic [MAX_LAYERS_W-1:0] layers_done_q, layers_done_d;
  logic                    armed_q;

  logic                    desc_ready;
  logic                    desc_hs;
  logic                    last_word;
  logic [WORD_IDX_W-1:0]   next_idx;
  logic                    epoch_flip;
  logic                    wr_start;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_w_hs;
  logic                    wr_done;
  logic                    wr_err;

  assign desc_hs    = bus.desc_valid && desc_ready;
  assign last_word  = (word_idx_q == WORD_IDX_W'(CFG_WORDS - 1));
  assign next_idx   = word_idx_q + WORD_IDX_W'(1);
  assign epoch_flip = flip_pending_q && (current_epoch != epoch_snap_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE: if (desc_hs) state_d = SEQ_RUN;
      SEQ_RUN:  if (wr_done && last_word) state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  // Word 0 comes straight from the bus so AW/W rise one cycle after acceptance.
  always_comb begin
    desc_ready = armed_q && (state_q == SEQ_IDLE) && !flip_pending_q;
    busy       = (state_q != SEQ_IDLE) || flip_pending_q;
    wr_start   = desc_hs || ((state_q == SEQ_RUN) && wr_done && !last_word);
    if (desc_hs) begin
      wr_addr = BASE_ADDR;
      wr_data = bus.desc.compute_cycles;
    end else begin
      wr_addr = word_addr(BASE_ADDR, next_idx);
      wr_data = desc_word(desc_q, next_idx);
    end
  end

  always_comb begin
    desc_d         = desc_q;
    word_idx_d     = word_idx_q;
    flip_pending_d = flip_pending_q;
    epoch_snap_d   = epoch_snap_q;
    resp_err_d     = resp_err_q || wr_err;
    layers_done_d  = layers_done_q;
    if (desc_hs) begin
      desc_d     = bus.desc;
      word_idx_d = '0;
    end else if ((state_q == SEQ_RUN) && wr_done) begin
      word_idx_d = last_word ? '0 : next_idx;
    end
    // Snapshot on the last W: config_manager cannot flip before it sees that word.
    if ((state_q == SEQ_RUN) && wr_w_hs && last_word) begin
      epoch_snap_d = current_epoch;
    end
    if (epoch_flip) begin
      flip_pending_d = 1'b0;
      layers_done_d  = layers_done_q + MAX_LAYERS_W'(1);
    end
    if ((state_q == SEQ_RUN) && wr_done && last_word) begin
      flip_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_q         <= '0;
      word_idx_q     <= '0;
      flip_pending_q <= 1'b0;
      epoch_snap_q   <= '0;
      resp_err_q     <= 1'b0;
      layers_done_q  <= '0;
      armed_q        <= 1'b0;
    end else begin
      desc_q         <= desc_d;
      word_idx_q     <= word_idx_d;
      flip_pending_q <= flip_pending_d;
      epoch_snap_q   <= epoch_snap_d;
      resp_err_q     <= resp_err_d;
      layers_done_q  <= layers_done_d;
      armed_q        <= 1'b1;
    end
  end

  assign bus.desc_ready = desc_ready;
  assign flip_pending   = flip_pending_q;
  assign resp_err       = resp_err_q;
  assign layers_done    = layers_done_q;

  config_loader_axil_single_write u_wr (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (wr_start),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .awaddr_o  (bus.m_axi_awaddr),
    .awvalid_o (bus.m_axi_awvalid),
    .awready_i (bus.m_axi_awready),
    .wdata_o   (bus.m_axi_wdata),
    .wstrb_o   (bus.m_axi_wstrb),
    .wvalid_o  (bus.m_axi_wvalid),
    .wready_i  (bus.m_axi_wready),
    .bresp_i   (bus.m_axi_bresp),
    .bvalid_i  (bus.m_axi_bvalid),
    .bready_o  (bus.m_axi_bready),
    .w_hs_o    (wr_w_hs),
    .done_o    (wr_done),
    .err_o     (wr_err)
  );

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: AXI-lite slave model with AW stall and
// error injection, epoch driven by the stimulus process.
module tb_config_loader;
  import config_loader_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] BASE = 32'h0000_1000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [EPOCH_WIDTH-1:0] epoch;
  logic                   busy;
  logic                   flip_pending;
  logic                   resp_err;
  logic [15:0]            layers_done;

  always #5 clk = ~clk;

  config_loader_if bus ();

  config_loader #(
    .BASE_ADDR    (BASE),
    .MAX_LAYERS_W (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .current_epoch (epoch),
    .busy          (busy),
    .flip_pending  (flip_pending),
    .resp_err      (resp_err),
    .layers_done   (layers_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // slave model state
  int          aw_cnt, w_cnt, b_cnt, aw_stall, err_b, viol;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  int          aw_cyc[$];
  int          w_cyc[$];
  logic        b_fire, prev_awv, prev_awr, prev_wv, prev_wr;
  logic [31:0] prev_awaddr, prev_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic layer_desc_t mk(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] c, input logic [31:0] d);
    layer_desc_t r;
    r.compute_cycles = a;
    r.config_bits    = b;
    r.pointer_walks  = c;
    r.data_size      = d;
    return r;
  endfunction

  // Handshakes are decided at the negedge for the following posedge.
  initial begin
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; viol = 0; b_fire = 1'b0;
    prev_awv = 1'b0; prev_awr = 1'b0; prev_wv = 1'b0; prev_wr = 1'b0;
    prev_awaddr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_fire = 1'b0;
        aw_log.delete(); w_log.delete(); aw_cyc.delete(); w_cyc.delete();
        prev_awv = 1'b0; prev_wv = 1'b0;
      end else begin
        if (prev_awv && !prev_awr && (!bus.m_axi_awvalid || bus.m_axi_awaddr != prev_awaddr)) viol++;
        if (prev_wv && !prev_wr && (!bus.m_axi_wvalid || bus.m_axi_wdata != prev_wdata)) viol++;
        if (b_fire) bus.m_axi_bvalid = 1'b0;
        if (!bus.m_axi_bvalid && aw_cnt > b_cnt && w_cnt > b_cnt) begin
          bus.m_axi_bvalid = 1'b1;
          bus.m_axi_bresp  = (b_cnt == err_b) ? 2'b10 : 2'b00;
        end
        if (bus.m_axi_awvalid && aw_stall > 0) begin
          bus.m_axi_awready = 1'b0;
          aw_stall--;
        end else begin
          bus.m_axi_awready = 1'b1;
        end
        bus.m_axi_wready = 1'b1;
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin
          if (aw_cnt != b_cnt) viol++;
          aw_log.push_back(bus.m_axi_awaddr);
          aw_cyc.push_back(cyc);
          aw_cnt++;
        end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          if (w_cnt != b_cnt) viol++;
          w_log.push_back(bus.m_axi_wdata);
          w_cyc.push_back(cyc);
          w_cnt++;
        end
        b_fire = bus.m_axi_bvalid && bus.m_axi_bready;
        if (b_fire) begin
          $display("axi write #%0d addr=%h data=%h bresp=%0d", b_cnt, aw_log[b_cnt], w_log[b_cnt],
                   bus.m_axi_bresp);
          b_cnt++;
        end
        prev_awv = bus.m_axi_awvalid; prev_awr = bus.m_axi_awready; prev_awaddr = bus.m_axi_awaddr;
        prev_wv  = bus.m_axi_wvalid;  prev_wr  = bus.m_axi_wready;  prev_wdata  = bus.m_axi_wdata;
      end
    end
  end

  task automatic send_desc(input string tag, input layer_desc_t d, input bit chk_lat);
    int n = 0;
    bus.desc_valid = 1'b1;
    bus.desc       = d;
    while (!bus.desc_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, bus.desc_ready, 1'b1);
    @(negedge clk);
    bus.desc_valid = 1'b0;
    if (chk_lat) begin
      chk({tag, "_lat_awvalid"}, bus.m_axi_awvalid, 1'b1);
      chk({tag, "_lat_wvalid"}, bus.m_axi_wvalid, 1'b1);
      chk({tag, "_lat_awaddr"}, bus.m_axi_awaddr, BASE);
      chk({tag, "_busy"}, busy, 1'b1);
    end
  endtask

  task automatic wait_b(input string tag, input int target);
    int n = 0;
    while (b_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, b_cnt, target);
  endtask

  task automatic wait_fp(input string tag);
    int n = 0;
    while (!flip_pending && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, flip_pending, 1'b1);
  endtask

  initial begin
    logic [31:0] t1_data[4];
    int base;
    int cnt;
    t1_data = '{32'd10, 32'hA5, 32'd3, 32'd64};
    bus.desc_valid = 1'b0;
    bus.desc       = '0;
    epoch          = '0;
    aw_stall       = 0;
    err_b          = -1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("rst_wvalid", bus.m_axi_wvalid, 1'b0);
    chk("rst_bready", bus.m_axi_bready, 1'b0);
    chk("rst_desc_ready", bus.desc_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flip_pending", flip_pending, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_layers_done", layers_done, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.desc_ready, 1'b1);

    // basic layer
    send_desc("t1", mk(32'd10, 32'hA5, 32'd3, 32'd64), 1'b1);
    wait_b("t1_b", 4);
    wait_fp("t1_fp");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), aw_log[i], BASE + 32'(4 * i));
      chk($sformatf("t1_data%0d", i), w_log[i], t1_data[i]);
    end
    chk("t1_wstrb", bus.m_axi_wstrb, 4'hF);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (!flip_pending || bus.desc_ready || !busy) cnt++;
    end
    chk("t1_hold_pending", cnt, 0);
    epoch = 8'd1;
    @(negedge clk);
    chk("t1_fp_clear", flip_pending, 1'b0);
    chk("t1_layers", layers_done, 16'd1);
    chk("t1_ready_back", bus.desc_ready, 1'b1);
    chk("t1_busy_clear", busy, 1'b0);

    // AW back-pressure, W completes first
    base = aw_cnt;
    aw_stall = 3;
    send_desc("t2", mk(32'd1, 32'd2, 32'd3, 32'd4), 1'b0);
    wait_b("t2_b", base + 4);
    chk("t2_aw_after_w", aw_cyc[base] - w_cyc[base], 3);
    chk("t2_aw_cnt", aw_cnt, base + 4);
    chk("t2_w_cnt", w_cnt, base + 4);
    chk("t2_addr0", aw_log[base], BASE);
    chk("t2_data0", w_log[base], 32'd1);
    chk("t2_data3", w_log[base + 3], 32'd4);
    wait_fp("t2_fp");
    epoch = 8'd2;
    @(negedge clk);
    chk("t2_layers", layers_done, 16'd2);

    // flow control: second descriptor waits for the flip
    base = aw_cnt;
    send_desc("t3a", mk(32'h11, 32'h22, 32'h33, 32'h44), 1'b0);
    bus.desc_valid = 1'b1;
    bus.desc       = mk(32'h55, 32'h66, 32'h77, 32'h88);
    wait_fp("t3_fp");
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.desc_ready) cnt++;
    end
    chk("t3_blocked", cnt, 0);
    chk("t3_no_5th_aw", aw_cnt, base + 4);
    epoch = 8'd3;
    cnt = 0;
    while (!bus.desc_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("t3b_accept", bus.desc_ready, 1'b1);
    @(negedge clk);
    bus.desc_valid = 1'b0;
    wait_b("t3b_b", base + 8);
    wait_fp("t3b_fp");
    chk("t3b_addr0", aw_log[base + 4], BASE);
    chk("t3b_data0", w_log[base + 4], 32'h55);
    chk("t3b_addr3", aw_log[base + 7], BASE + 32'd12);
    chk("t3b_data3", w_log[base + 7], 32'h88);
    epoch = 8'd4;
    @(negedge clk);
    chk("t3_layers", layers_done, 16'd4);
    chk("t3_no_err", resp_err, 1'b0);

    // SLVERR on word 1 does not abort the layer
    base = b_cnt;
    err_b = base + 1;
    send_desc("t4", mk(32'd5, 32'd6, 32'd7, 32'd8), 1'b0);
    wait_b("t4_b", base + 4);
    wait_fp("t4_fp");
    chk("t4_resp_err", resp_err, 1'b1);
    chk("t4_aw_cnt", aw_cnt, base + 4);
    chk("t4_data3", w_log[base + 3], 32'd8);
    err_b = -1;
    epoch = 8'd5;
    @(negedge clk);
    chk("t4_layers", layers_done, 16'd5);
    chk("t4_err_sticky", resp_err, 1'b1);

    // epoch wrap 0xFF -> 0x00
    epoch = 8'hFF;
    @(negedge clk);
    base = b_cnt;
    send_desc("t5", mk(32'd21, 32'd22, 32'd23, 32'd24), 1'b0);
    wait_b("t5_b", base + 4);
    wait_fp("t5_fp");
    repeat (3) @(negedge clk);
    chk("t5_still_pending", flip_pending, 1'b1);
    epoch = 8'h00;
    @(negedge clk);
    chk("t5_fp_clear", flip_pending, 1'b0);
    chk("t5_layers", layers_done, 16'd6);

    // asynchronous reset in the middle of word 2
    base = b_cnt;
    send_desc("t6", mk(32'd9, 32'd9, 32'd9, 32'd9), 1'b0);
    wait_b("t6_b2", base + 2);
    cnt = 0;
    while (!bus.m_axi_awvalid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("t6_in_send", bus.m_axi_awvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("t6_wvalid", bus.m_axi_wvalid, 1'b0);
    chk("t6_bready", bus.m_axi_bready, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_resp_err", resp_err, 1'b0);
    chk("t6_layers", layers_done, 16'd0);
    chk("t6_desc_ready", bus.desc_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_desc("t6r", mk(32'd7, 32'd8, 32'd9, 32'd10), 1'b0);
    wait_b("t6r_b", 4);
    chk("t6r_addr0", aw_log[0], BASE);
    chk("t6r_data0", w_log[0], 32'd7);
    chk("t6r_addr2", aw_log[2], BASE + 32'd8);
    wait_fp("t6r_fp");
    epoch = 8'd1;
    @(negedge clk);
    chk("t6r_layers", layers_done, 16'd1);

    chk("protocol_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- AXI-lite write master that drives the host-side config port of config_manager.
- Accepts one layer descriptor per valid/ready handshake and issues four single-beat writes in this order: compute_cycles, config_bits, pointer_walks, data_size.
- Holds off the next descriptor until config_manager reports a flip via current_epoch advancing, so the shadow register is never overwritten before it is consumed.

Parameters:
- BASE_ADDR, 0, address of word 0; word i goes to BASE_ADDR + 4*i.
- MAX_LAYERS_W, 16, width of the layers_done counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous assert, active-low
- desc_valid  input  1  descriptor available
- desc_ready  output  1  descriptor accepted this cycle when high with desc_valid
- desc  input  layer_desc_t (4x32)  compute_cycles, config_bits, pointer_walks, data_size
- m_axi_awaddr  output  `ADDR_WIDTH  write address
- m_axi_awvalid  output  1  address valid
- m_axi_awready  input  1  address ready
- m_axi_wdata  output  32  write data
- m_axi_wstrb  output  4  always 4'hF
- m_axi_wvalid  output  1  data valid
- m_axi_wready  input  1  data ready
- m_axi_bresp  input  2  write response
- m_axi_bvalid  input  1  response valid
- m_axi_bready  output  1  response ready
- current_epoch  input  `EPOCH_WIDTH  epoch from config_manager
- busy  output  1  descriptor in flight or flip pending
- flip_pending  output  1  all 4 words written, waiting for epoch change
- resp_err  output  1  sticky; set when any BRESP != 2'b00
- layers_done  output  MAX_LAYERS_W  count of layers confirmed flipped

Behaviour:
- Reset values: all outputs 0; state IDLE; word_idx 0; descriptor register 0.
- Reset mid-transaction drops awvalid, wvalid and bready immediately (asynchronous).
- States and transitions:
  - IDLE: desc_ready = !flip_pending. On desc_valid && desc_ready, latch desc, set word_idx = 0, go to SEND.
  - SEND: awvalid and wvalid are asserted together on entry. Each stays high until its own handshake and is tracked by aw_done/w_done flags. Any handshake order is legal, including W before AW and both in the same cycle. awaddr and wdata are stable while valid. When aw_done and w_done are both set, clear the flags and go to RESP.
  - RESP: bready = 1. On bvalid:
    - Set resp_err if bresp != 0.
    - If word_idx == 3: go to IDLE with flip_pending = 1.
    - Otherwise: word_idx++, go to SEND.
- Epoch snapshot:
  - Captured from current_epoch on the W handshake of word 3, which precedes any possible flip.
  - flip_pending clears on the first cycle current_epoch != snapshot. layers_done increments in that same cycle.
  - Comparison is inequality only, so epoch wrap-around is safe.
- If the flip occurs while still in RESP for word 3, the epoch change is detected as soon as flip_pending is set, i.e. one cycle later.
- layers_done wraps modulo 2^MAX_LAYERS_W.
- busy = (state != IDLE) || flip_pending.
- Latency with an always-ready slave:
  - desc handshake -> first awvalid: 1 cycle.
  - Each word: SEND ≥1 cycle + RESP ≥1 cycle.
  - config_manager accepts AW and W serially, so a word takes ≥3 cycles.
- Protocol checks: awvalid and wvalid never deassert without their ready. No new AW is issued while a B is outstanding, so only one transaction is in flight.
- A BRESP error does not abort the sequence; the remaining words are still sent.

Decomposition:
- Shared package flexpipe_pkg.sv:
  - layer_desc_t packed struct of four 32-bit fields, the same field order as layer_config_t.
  - CFG_WORDS = 4 constant.
  - AXI_RESP_OKAY = 2'b00 constant.
- Optional sub-module axil_single_write: one AW+W+B transaction with start/done/err, instantiated once; the sequencing FSM sits above it.

Test Plan:
- Basic layer: one desc {10,0xA5,3,64}, slave always ready, epoch flips 5 cycles after the last B.
  - Expect AW addresses BASE+0/4/8/12 with data 10/0xA5/3/64 in order.
  - flip_pending = 1 until the epoch goes 0->1, then layers_done = 1 and desc_ready returns.
- Back-pressure: awready low for 3 cycles while wready is high.
  - W completes first; awvalid and awaddr are held stable; no duplicate W; B is taken exactly once per word.
- Flow control: two descriptors queued, epoch held constant.
  - The second desc is not accepted (desc_ready = 0) and no 5th AW appears.
  - After epoch 0->1, the second layer's writes start; layers_done = 2 after the next flip.
- Error response: bresp = 2'b10 on word 1.
  - resp_err = 1 sticky; words 2 and 3 are still sent; flip_pending is still set.
- Epoch wrap: preload epoch to max (all ones), complete a layer, flip to 0.
  - flip_pending clears and layers_done increments.
- Reset mid-word: assert rst_n low during SEND of word 2.
  - Valids drop asynchronously and all outputs return to 0.
  - After release, a fresh desc starts again at word 0, address BASE+0.
